// File: rtl/fdp_pkg.sv
// Shared definitions for the final_data_path multicycle core: opcodes,
// FSM state encodings, ALU operation codes and the immediate sign-extender.
package fdp_pkg;

    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 256;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_J    = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [4:0] {
        S_FETCH    = 5'd0,
        S_DECODE   = 5'd1,
        S_MEMADDR  = 5'd2,
        S_MEMREAD  = 5'd3,
        S_MEMWB    = 5'd4,
        S_MEMWRITE = 5'd5,
        S_EXEC_R   = 5'd6,
        S_RWB      = 5'd7,
        S_EXEC_I   = 5'd8,
        S_IWB      = 5'd9,
        S_BRANCH   = 5'd10,
        S_JUMP     = 5'd11,
        S_HALT     = 5'd12
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    function automatic logic signed [DATA_W-1:0] sext_imm4(input logic [3:0] imm);
        return {{(DATA_W-4){imm[3]}}, imm};
    endfunction

endpackage

// File: rtl/fdp_alu.sv
// Combinational 16-bit ALU: ADD/SUB/AND/OR/signed SLT, plus operand equality
// used by the branch decision.
import fdp_pkg::*;

module fdp_alu (
    input  alu_op_t                  op,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] y,
    output logic                     eq
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = (a < b) ? 16'sd1 : 16'sd0;
            default: y = '0;
        endcase
    end

    assign eq = (a == b);

endmodule

// File: rtl/final_data_path.sv
// 16-bit multicycle CPU top: FSM, register file, latches and unified memory.
import fdp_pkg::*;

module final_data_path (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [15:0] writeDataIn,
    output logic [15:0] IROut,
    output logic [15:0] A_Input,
    output logic [15:0] B_Input,
    output logic [15:0] ALU_Out,
    output logic [4:0]  next_state,
    output logic [4:0]  current_state,
    output logic [15:0] MemOut
);

    state_t state, state_nxt;

    logic [DATA_W-1:0] pc, ir, a_q, b_q, alu_out_q, mdr;
    logic [DATA_W-1:0] regs [16];

    logic [DATA_W-1:0] mem [MEM_DEPTH] = '{default: 16'h0000};

    logic [3:0] opcode, rd, rs, rt, port2_sel;
    logic [DATA_W-1:0] rdata1, rdata2;
    logic signed [DATA_W-1:0] imm_ext, alu_a, alu_b, alu_y;
    logic [7:0] mem_addr;
    logic       alu_eq, reg_we;
    alu_op_t    r_op, alu_op;

    assign opcode    = ir[15:12];
    assign rd        = ir[11:8];
    assign rs        = ir[7:4];
    assign rt        = ir[3:0];
    assign imm_ext   = sext_imm4(ir[3:0]);
    // Port 2 supplies rt for R-type, and rd for I-type (SW data, BEQ compare)
    assign port2_sel = (opcode <= OP_SLT) ? rt : rd;
    assign rdata1    = (rs == 4'd0) ? '0 : regs[rs];
    assign rdata2    = (port2_sel == 4'd0) ? '0 : regs[port2_sel];

    assign mem_addr = (state == S_FETCH) ? pc[7:0] : alu_out_q[7:0];
    assign MemOut   = mem[mem_addr];

    always_comb begin
        r_op = ALU_ADD;
        case (opcode)
            OP_SUB:  r_op = ALU_SUB;
            OP_AND:  r_op = ALU_AND;
            OP_OR:   r_op = ALU_OR;
            OP_SLT:  r_op = ALU_SLT;
            default: r_op = ALU_ADD;
        endcase
    end

    // DECODE reuses the ALU for the branch target PC + sext(imm)
    assign alu_a  = (state == S_DECODE) ? pc : a_q;
    assign alu_b  = (state == S_EXEC_R || state == S_BRANCH) ? b_q : imm_ext;
    assign alu_op = (state == S_EXEC_R) ? r_op : ALU_ADD;

    fdp_alu u_alu (
        .op (alu_op),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y),
        .eq (alu_eq)
    );

    assign reg_we      = (state == S_MEMWB) || (state == S_RWB) || (state == S_IWB);
    assign writeDataIn = (state == S_MEMWB) ? mdr : alu_out_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_FETCH;
            pc        <= '0;
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr       <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_FETCH: begin
                    ir <= MemOut;
                    pc <= pc + 16'd1;
                end
                S_DECODE: begin
                    a_q       <= rdata1;
                    b_q       <= rdata2;
                    alu_out_q <= alu_y;
                end
                S_MEMADDR, S_EXEC_R, S_EXEC_I: alu_out_q <= alu_y;
                S_MEMREAD: mdr <= MemOut;
                S_BRANCH:  if (alu_eq) pc <= alu_out_q;
                S_JUMP:    pc <= {8'h00, ir[7:0]};
                default: ;
            endcase
            if (reg_we && rd != 4'd0) regs[rd] <= writeDataIn;
        end
    end

    // Memory contents survive reset
    always_ff @(posedge CLK) begin
        if (state == S_MEMWRITE) mem[alu_out_q[7:0]] <= b_q;
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: state_nxt = S_EXEC_R;
                    OP_ADDI:      state_nxt = S_EXEC_I;
                    OP_LW, OP_SW: state_nxt = S_MEMADDR;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_HALT:      state_nxt = S_HALT;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADDR: state_nxt = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_nxt = S_MEMWB;
            S_EXEC_R:  state_nxt = S_RWB;
            S_EXEC_I:  state_nxt = S_IWB;
            S_HALT:    state_nxt = S_HALT;
            default:   state_nxt = S_FETCH;
        endcase
    end

    assign IROut         = ir;
    assign A_Input       = a_q;
    assign B_Input       = b_q;
    assign ALU_Out       = alu_out_q;
    assign current_state = state;
    assign next_state    = state_nxt;

endmodule

// File: tb/tb_final_data_path.sv
// Directed bench for final_data_path: loads a small program into the core's
// memory and walks it instruction by instruction with hand-computed values.
module tb_final_data_path;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] writeDataIn, IROut, A_Input, B_Input, ALU_Out, MemOut;
    logic [4:0]  next_state, current_state;

    int checks = 0;
    int errors = 0;

    final_data_path dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .writeDataIn   (writeDataIn),
        .IROut         (IROut),
        .A_Input       (A_Input),
        .B_Input       (B_Input),
        .ALU_Out       (ALU_Out),
        .next_state    (next_state),
        .current_state (current_state),
        .MemOut        (MemOut)
    );

    always #5 CLK = ~CLK;

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic load_program();
        dut.mem[0]     = 16'h5105;  // ADDI R1,R0,5
        dut.mem[1]     = 16'h5203;  // ADDI R2,R0,3
        dut.mem[2]     = 16'h1312;  // SUB  R3,R1,R2
        dut.mem[3]     = 16'h4421;  // SLT  R4,R2,R1
        dut.mem[4]     = 16'h7301;  // SW   R3,1(R0)
        dut.mem[5]     = 16'h6501;  // LW   R5,1(R0)
        dut.mem[6]     = 16'h8121;  // BEQ  R1,R2,+1 (not taken)
        dut.mem[7]     = 16'h5205;  // ADDI R2,R0,5
        dut.mem[8]     = 16'h8121;  // BEQ  R1,R2,+1 (taken)
        dut.mem[9]     = 16'h560F;  // skipped
        dut.mem[10]    = 16'h9040;  // J 0x40
        dut.mem[8'h40] = 16'h0612;  // ADD  R6,R1,R2
        dut.mem[8'h41] = 16'h3713;  // OR   R7,R1,R3
        dut.mem[8'h42] = 16'hF000;  // HALT
    endtask

    task automatic test_reset();
        RST_N = 1'b1;
        #1 RST_N = 1'b0;
        #1 load_program();
        cycles(2);
        checks++; if (current_state !== 5'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", current_state); end
        checks++; if (next_state !== 5'd1) begin errors++; $display("FAIL rst_next got=%0d exp=1", next_state); end
        checks++; if (IROut !== 16'h0000) begin errors++; $display("FAIL rst_ir got=%h exp=0000", IROut); end
        checks++; if (ALU_Out !== 16'h0000) begin errors++; $display("FAIL rst_aluout got=%h exp=0000", ALU_Out); end
        checks++; if (A_Input !== 16'h0000 || B_Input !== 16'h0000) begin errors++; $display("FAIL rst_ab got=%h/%h exp=0000/0000", A_Input, B_Input); end
        checks++; if (writeDataIn !== 16'h0000) begin errors++; $display("FAIL rst_wdata got=%h exp=0000", writeDataIn); end
        checks++; if (MemOut !== 16'h5105) begin errors++; $display("FAIL rst_memout got=%h exp=5105", MemOut); end
        RST_N = 1'b1;
    endtask

    task automatic test_addi();
        cycles(1);
        checks++; if (IROut !== 16'h5105 || current_state !== 5'd1) begin errors++; $display("FAIL addi1_fetch ir=%h st=%0d exp=5105/1", IROut, current_state); end
        checks++; if (next_state !== 5'd8) begin errors++; $display("FAIL addi1_next got=%0d exp=8", next_state); end
        cycles(2);
        checks++; if (current_state !== 5'd9 || writeDataIn !== 16'h0005) begin errors++; $display("FAIL addi1_wb st=%0d wd=%h exp=9/0005", current_state, writeDataIn); end
        cycles(1);
        checks++; if (current_state !== 5'd0) begin errors++; $display("FAIL addi1_done got=%0d exp=0", current_state); end
        cycles(1);
        checks++; if (IROut !== 16'h5203) begin errors++; $display("FAIL addi2_fetch got=%h exp=5203", IROut); end
        cycles(2);
        checks++; if (current_state !== 5'd9 || writeDataIn !== 16'h0003) begin errors++; $display("FAIL addi2_wb st=%0d wd=%h exp=9/0003", current_state, writeDataIn); end
        cycles(1);
    endtask

    task automatic test_rtype();
        cycles(1);
        checks++; if (IROut !== 16'h1312) begin errors++; $display("FAIL sub_fetch got=%h exp=1312", IROut); end
        cycles(1);
        checks++; if (current_state !== 5'd6 || A_Input !== 16'h0005 || B_Input !== 16'h0003) begin errors++; $display("FAIL sub_exec st=%0d a=%h b=%h exp=6/0005/0003", current_state, A_Input, B_Input); end
        cycles(1);
        checks++; if (current_state !== 5'd7 || ALU_Out !== 16'h0002) begin errors++; $display("FAIL sub_result st=%0d alu=%h exp=7/0002", current_state, ALU_Out); end
        cycles(1);
        cycles(1);
        checks++; if (IROut !== 16'h4421) begin errors++; $display("FAIL slt_fetch got=%h exp=4421", IROut); end
        cycles(2);
        checks++; if (current_state !== 5'd7 || ALU_Out !== 16'h0001) begin errors++; $display("FAIL slt_result st=%0d alu=%h exp=7/0001", current_state, ALU_Out); end
        cycles(1);
    endtask

    task automatic test_mem();
        cycles(1);
        checks++; if (IROut !== 16'h7301) begin errors++; $display("FAIL sw_fetch got=%h exp=7301", IROut); end
        cycles(1);
        checks++; if (current_state !== 5'd2 || next_state !== 5'd5 || B_Input !== 16'h0002) begin errors++; $display("FAIL sw_addr st=%0d nx=%0d b=%h exp=2/5/0002", current_state, next_state, B_Input); end
        cycles(1);
        checks++; if (current_state !== 5'd5 || ALU_Out !== 16'h0001) begin errors++; $display("FAIL sw_write st=%0d alu=%h exp=5/0001", current_state, ALU_Out); end
        cycles(1);
        checks++; if (current_state !== 5'd0) begin errors++; $display("FAIL sw_done got=%0d exp=0", current_state); end
        cycles(1);
        checks++; if (IROut !== 16'h6501) begin errors++; $display("FAIL lw_fetch got=%h exp=6501", IROut); end
        cycles(2);
        checks++; if (current_state !== 5'd3 || MemOut !== 16'h0002 || next_state !== 5'd4) begin errors++; $display("FAIL lw_read st=%0d mem=%h nx=%0d exp=3/0002/4", current_state, MemOut, next_state); end
        cycles(1);
        checks++; if (current_state !== 5'd4 || writeDataIn !== 16'h0002) begin errors++; $display("FAIL lw_wb st=%0d wd=%h exp=4/0002", current_state, writeDataIn); end
        cycles(1);
        checks++; if (current_state !== 5'd0) begin errors++; $display("FAIL lw_done got=%0d exp=0", current_state); end
    endtask

    task automatic test_branch();
        cycles(1);
        checks++; if (IROut !== 16'h8121 || next_state !== 5'd10) begin errors++; $display("FAIL beq_nt_fetch ir=%h nx=%0d exp=8121/10", IROut, next_state); end
        cycles(1);
        checks++; if (current_state !== 5'd10 || A_Input !== 16'h0003 || B_Input !== 16'h0005 || ALU_Out !== 16'h0008) begin errors++; $display("FAIL beq_nt_state st=%0d a=%h b=%h alu=%h exp=10/0003/0005/0008", current_state, A_Input, B_Input, ALU_Out); end
        cycles(1);
        checks++; if (current_state !== 5'd0) begin errors++; $display("FAIL beq_nt_done got=%0d exp=0", current_state); end
        cycles(1);
        checks++; if (IROut !== 16'h5205) begin errors++; $display("FAIL beq_nt_target got=%h exp=5205", IROut); end
        cycles(2);
        checks++; if (writeDataIn !== 16'h0005) begin errors++; $display("FAIL addi_r2_wb got=%h exp=0005", writeDataIn); end
        cycles(1);
        cycles(1);
        checks++; if (IROut !== 16'h8121) begin errors++; $display("FAIL beq_t_fetch got=%h exp=8121", IROut); end
        cycles(1);
        checks++; if (current_state !== 5'd10 || A_Input !== B_Input || ALU_Out !== 16'h000A) begin errors++; $display("FAIL beq_t_state st=%0d a=%h b=%h alu=%h exp=10/0005/0005/000a", current_state, A_Input, B_Input, ALU_Out); end
        cycles(1);
        cycles(1);
        checks++; if (IROut !== 16'h9040) begin errors++; $display("FAIL beq_t_target got=%h exp=9040", IROut); end
    endtask

    task automatic test_jump();
        cycles(1);
        checks++; if (current_state !== 5'd11) begin errors++; $display("FAIL j_state got=%0d exp=11", current_state); end
        cycles(1);
        cycles(1);
        checks++; if (IROut !== 16'h0612) begin errors++; $display("FAIL j_target got=%h exp=0612", IROut); end
        cycles(2);
        checks++; if (current_state !== 5'd7 || ALU_Out !== 16'h000A) begin errors++; $display("FAIL add_result st=%0d alu=%h exp=7/000a", current_state, ALU_Out); end
        cycles(1);
        cycles(1);
        checks++; if (IROut !== 16'h3713) begin errors++; $display("FAIL or_fetch got=%h exp=3713", IROut); end
        cycles(2);
        checks++; if (ALU_Out !== 16'h0007) begin errors++; $display("FAIL or_result got=%h exp=0007", ALU_Out); end
        cycles(1);
    endtask

    task automatic test_halt();
        cycles(1);
        checks++; if (IROut !== 16'hF000 || next_state !== 5'd12) begin errors++; $display("FAIL halt_fetch ir=%h nx=%0d exp=f000/12", IROut, next_state); end
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            checks++; if (current_state !== 5'd12 || next_state !== 5'd12) begin errors++; $display("FAIL halt_hold cyc=%0d st=%0d nx=%0d exp=12/12", i, current_state, next_state); end
        end
    endtask

    task automatic test_reset_mid_lw();
        RST_N = 1'b0;
        cycles(2);
        RST_N = 1'b1;
        cycles(20);
        cycles(3);
        checks++; if (current_state !== 5'd3 || IROut !== 16'h6501) begin errors++; $display("FAIL midlw_reach st=%0d ir=%h exp=3/6501", current_state, IROut); end
        RST_N = 1'b0;
        #1;
        checks++; if (current_state !== 5'd0 || next_state !== 5'd1) begin errors++; $display("FAIL midlw_state st=%0d nx=%0d exp=0/1", current_state, next_state); end
        checks++; if (IROut !== 16'h0 || A_Input !== 16'h0 || B_Input !== 16'h0 || ALU_Out !== 16'h0 || writeDataIn !== 16'h0) begin errors++; $display("FAIL midlw_latches ir=%h a=%h b=%h alu=%h wd=%h exp=all 0000", IROut, A_Input, B_Input, ALU_Out, writeDataIn); end
        checks++; if (MemOut !== 16'h5105) begin errors++; $display("FAIL midlw_memout got=%h exp=5105", MemOut); end
        @(negedge CLK);
        RST_N = 1'b1;
        cycles(1);
        checks++; if (IROut !== 16'h5105 || current_state !== 5'd1) begin errors++; $display("FAIL midlw_restart ir=%h st=%0d exp=5105/1", IROut, current_state); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_rtype();
        test_mem();
        test_branch();
        test_jump();
        test_halt();
        test_reset_mid_lw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
